// File: rtl/aes_pkg.sv
// Shared widths, default core latency and feeder FSM encoding for the AES-192 CTR wrapper.
package aes_pkg;

  localparam int unsigned BLK_W          = 128;
  localparam int unsigned KEY_W          = 192;
  localparam int unsigned AES192_LATENCY = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/aes_ctr_delay.sv
// Payload/valid delay line matched to the aes_192 pipeline depth.
// Shifts every cycle; only the valid bits are reset, so a reset discards in-flight beats.
module aes_ctr_delay
  import aes_pkg::*;
#(
  parameter int unsigned Latency = AES192_LATENCY
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [BLK_W-1:0] data_i,
  output logic             valid_o,
  output logic [BLK_W-1:0] data_o,
  output logic             any_valid_o
);

  logic [Latency-1:0] valid_q, valid_d;
  logic [BLK_W-1:0]   data_q [Latency];
  logic [BLK_W-1:0]   data_d [Latency];

  // Next-state: shift one stage per cycle, stage 0 takes the new beat (or a bubble)
  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int i = 1; i < int'(Latency); i++) begin
      data_d[i] = data_q[i-1];
    end
  end

  // Valid bits carry flow control, so they need the async reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload contents are qualified by the valid bits and need no reset
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  // Outputs: last stage plus an occupancy flag used to detect an empty line
  always_comb begin
    valid_o     = valid_q[Latency-1];
    data_o      = data_q[Latency-1];
    any_valid_o = |valid_q;
  end

endmodule

// File: rtl/aes_ctr_feeder.sv
// CTR-mode wrapper around a fully pipelined aes_192 core: drives counter and key into the core,
// delays payload alongside it and XORs the keystream onto the delayed payload.
module aes_ctr_feeder
  import aes_pkg::*;
#(
  parameter int unsigned LATENCY = AES192_LATENCY,
  parameter int unsigned CTR_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic [KEY_W-1:0] cfg_key,
  input  logic [CNT_W-1:0] cfg_nblocks,
  input  logic             in_valid,
  input  logic [BLK_W-1:0] in_data,
  output logic             in_ready,
  output logic [BLK_W-1:0] aes_state,
  output logic [KEY_W-1:0] aes_key,
  input  logic [BLK_W-1:0] aes_out,
  output logic             out_valid,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  feeder_state_e    state_q, state_d;
  logic [BLK_W-1:0] ctr_q, ctr_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic             accept;
  logic             dl_valid;
  logic             dl_any;
  logic [BLK_W-1:0] dl_data;

  assign accept = (state_q == StRun) && in_valid;

  // State and job registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ctr_q       <= '0;
      key_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      key_q       <= key_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state: a zero-length job goes straight to DRAIN so done still fires
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_start) state_d = (cfg_nblocks == '0) ? StDrain : StRun;
      StRun:   if (accept && (remaining_q == CNT_W'(1))) state_d = StDrain;
      StDrain: if (!dl_any) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Job datapath: config latched only from IDLE; low counter field wraps without carry
  always_comb begin
    ctr_d       = ctr_q;
    key_d       = key_q;
    remaining_d = remaining_q;
    if ((state_q == StIdle) && cfg_start) begin
      ctr_d       = cfg_iv;
      key_d       = cfg_key;
      remaining_d = cfg_nblocks;
    end else if (accept) begin
      ctr_d[CTR_W-1:0] = ctr_q[CTR_W-1:0] + CTR_W'(1);
      remaining_d      = remaining_q - CNT_W'(1);
    end
  end

  // Outputs: core samples ctr on the accept edge, so the payload enters the line on that edge too
  always_comb begin
    in_ready  = (state_q == StRun);
    busy      = (state_q != StIdle);
    done      = (state_q == StDrain) && !dl_any;
    aes_state = ctr_q;
    aes_key   = key_q;
    out_valid = dl_valid;
    out_data  = aes_out ^ dl_data;
  end

  aes_ctr_delay #(
    .Latency(LATENCY)
  ) u_delay (
    .clk_i      (clk),
    .reset_i    (reset),
    .valid_i    (accept),
    .data_i     (in_data),
    .valid_o    (dl_valid),
    .data_o     (dl_data),
    .any_valid_o(dl_any)
  );

endmodule

// File: tb/tb_aes_ctr_feeder.sv
// Bench for aes_ctr_feeder with a behavioural AES-192 core model on the core ports.
module tb_aes_ctr_feeder;
  import aes_pkg::*;

  localparam int LAT   = 24;
  localparam int CTR_W = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start;
  logic [127:0]     cfg_iv;
  logic [191:0]     cfg_key;
  logic [CNT_W-1:0] cfg_nblocks;
  logic             in_valid;
  logic [127:0]     in_data;
  logic             in_ready;
  logic [127:0]     aes_state;
  logic [191:0]     aes_key;
  logic [127:0]     aes_out;
  logic             out_valid;
  logic [127:0]     out_data;
  logic             busy;
  logic             done;

  aes_ctr_feeder #(
    .LATENCY(LAT),
    .CTR_W  (CTR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_iv     (cfg_iv),
    .cfg_key    (cfg_key),
    .cfg_nblocks(cfg_nblocks),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .aes_state  (aes_state),
    .aes_key    (aes_key),
    .aes_out    (aes_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // ---------------- AES-192 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [191:0] key);
    logic [31:0] w [52];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 12; rnd++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      s = t;
      if (rnd < 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // Core stand-in: samples state/key each edge, result emerges LAT edges downstream
  logic [127:0] core_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= aes_enc(aes_state, aes_key);
  end
  assign aes_out = core_pipe[LAT-1];

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q [$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  bit           m_busy = 1'b0;
  int unsigned  m_rem = 0;
  logic [127:0] m_ctr = '0;
  logic [191:0] m_key = '0;
  bit           m_done_now = 1'b0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit           ev;
    logic [127:0] ed;
    ev = 1'b0;
    ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev = 1'b1;
      ed = exp_q[0].data;
    end
    m_done_now = m_busy && (m_rem == 0) && (exp_q.size() == 0);
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_data", out_data, ed);
    chk("in_ready", in_ready, m_busy && (m_rem != 0));
    chk("busy", busy, m_busy);
    chk("done", done, m_done_now);
    chk("aes_state", aes_state, m_ctr);
    chk("aes_key", aes_key, m_key);
    if (ev) void'(exp_q.pop_front());
  endtask

  // Apply the spec rules to the inputs about to be sampled at the next edge
  task automatic model_edge();
    exp_t e;
    if (!m_busy) begin
      if (cfg_start) begin
        m_busy = 1'b1;
        m_rem  = cfg_nblocks;
        m_ctr  = cfg_iv;
        m_key  = cfg_key;
      end
    end else if (m_rem != 0) begin
      if (in_valid) begin
        e.data = aes_enc(m_ctr, m_key) ^ in_data;
        e.due  = cyc + LAT;
        exp_q.push_back(e);
        m_ctr  = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
        m_rem  = m_rem - 1;
      end
    end else if (m_done_now) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic start_job(input logic [127:0] iv, input logic [191:0] key, input int n);
    cfg_iv      = iv;
    cfg_key     = key;
    cfg_nblocks = CNT_W'(n);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && busy; k++) tick();
    chk(name, busy, 1'b0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [127:0] iv;
    logic [191:0] key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [3];
  logic [127:0] iv_w, iv_a;
  logic [191:0] key_a;
  logic [31:0]  wrap_lo [4];
  logic [127:0] st [4];
  logic [4:0]   op;
  int           hs, first_out, last_out, n_out, c0;
  bit           pat [5];

  initial begin
    vecs[0] = '{128'h00112233445566778899aabbccddeeff,
                192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                128'h0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734,
                192'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da5,
                128'h0, 128'hf9fb29aefc384a250340d833b87ebc00};
    vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734,
                192'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da5,
                {128{1'b1}}, 128'h0604d65103c7b5dafcbf27cc478143ff};
    wrap_lo = '{32'hfffffffe, 32'hffffffff, 32'h00000000, 32'h00000001};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    build_sbox();
    reset = 1'b1; cfg_start = 1'b0; cfg_iv = '0; cfg_key = '0; cfg_nblocks = '0;
    in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aes_state", aes_state, 128'h0);
    chk("rst_aes_key", aes_key, 192'h0);
    reset = 1'b0;

    // Known single-block vectors
    for (int i = 0; i < 3; i++) begin
      start_job(vecs[i].iv, vecs[i].key, 1);
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      hs = cyc;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 40 && !out_valid; k++) tick();
      chk($sformatf("vec%0d_latency", i), out_valid ? 192'(cyc - hs) : 192'(0), 192'(24));
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      drain($sformatf("vec%0d_end", i));
    end

    // Counter wrap with back-to-back beats
    iv_w = {96'h0123456789abcdef01234567, 32'hfffffffe};
    start_job(iv_w, {rand128(), 64'h0123456789abcdef}, 4);
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_data = rand128();
      st[j]   = aes_state;
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) chk($sformatf("wrap_ctr%0d", j), st[j], {iv_w[127:32], wrap_lo[j]});
    n_out = 0; first_out = 0; last_out = 0;
    for (int k = 0; k < 60 && busy; k++) begin
      if (out_valid) begin
        if (n_out == 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      tick();
    end
    chk("wrap_outs", 192'(n_out), 192'(4));
    chk("wrap_back2back", 192'(last_out - first_out), 192'(3));

    // Bubbles in the input stream
    start_job(rand128(), {rand128(), 64'h55aa55aa55aa55aa}, 3);
    c0 = cyc;
    for (int j = 0; j < 5; j++) begin
      in_valid = pat[j];
      in_data  = rand128();
      tick();
    end
    in_valid = 1'b0;
    chk("bubble_ready_low", in_ready, 1'b0);
    for (int k = 0; k < 40 && cyc < c0 + 24; k++) tick();
    for (int j = 0; j < 5; j++) begin
      op[j] = out_valid;
      tick();
    end
    chk("bubble_out_pattern", op, 5'b11001);
    drain("bubble_end");

    // Zero-length job
    start_job(rand128(), {rand128(), 64'h1}, 0);
    chk("zero_done", done, 1'b1);
    chk("zero_in_ready", in_ready, 1'b0);
    tick();
    chk("zero_busy_after", busy, 1'b0);

    // cfg_start while running must not disturb latched config
    iv_a  = rand128();
    key_a = {rand128(), 64'hfeedfacecafebeef};
    start_job(iv_a, key_a, 3);
    in_valid = 1'b1; in_data = rand128();
    tick();
    in_valid = 1'b0;
    cfg_iv = rand128(); cfg_key = {rand128(), 64'h2}; cfg_nblocks = 16'd7; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("midstart_key", aes_key, key_a);
    chk("midstart_ctr", aes_state, {iv_a[127:32], iv_a[31:0] + 32'd1});
    in_valid = 1'b1;
    for (int k = 0; k < 10 && in_ready; k++) begin
      in_data = rand128();
      tick();
    end
    in_valid = 1'b0;
    drain("midstart_end");

    // Randomised jobs against the model
    for (int r = 0; r < 6; r++) begin
      start_job(rand128(), {rand128(), $urandom, $urandom}, $urandom_range(1, 6));
      for (int k = 0; k < 80 && busy; k++) begin
        in_valid    = $urandom_range(0, 1) == 1;
        in_data     = rand128();
        cfg_start   = $urandom_range(0, 7) == 0;
        cfg_iv      = rand128();
        cfg_nblocks = CNT_W'($urandom_range(0, 5));
        tick();
      end
      in_valid  = 1'b0;
      cfg_start = 1'b0;
      chk($sformatf("rand%0d_end", r), busy, 1'b0);
    end

    // Reset while results are emerging
    start_job(rand128(), {rand128(), 64'h3}, 10);
    in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_data = rand128();
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) tick();
    chk("pre_reset_out_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_busy = 1'b0; m_rem = 0; m_ctr = '0; m_key = '0; m_done_now = 1'b0;
    n_out = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid || done) n_out++;
    end
    chk("post_rst_quiet", 192'(n_out), 192'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
